pipe_map_render: RTL

PIPE_MAP_RENDER -- requirements
Module: pipe_map_render

---
 rtl/pipe_map_render.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_map_render.sv
// Three-stage tile-map renderer for a 640x480 VGA beam: pipe tiles come from a
// small tile RAM, and a robot sprite position is latched once per frame.
module pipe_map_render #(
  parameter int TILE_COLS = 20,
  parameter int TILE_ROWS = 15
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic       p_tick,
  input  logic       video_on,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       map_we,
  input  logic [8:0] map_addr,
  input  logic [2:0] map_data,
  input  logic [4:0] robot_col,
  input  logic [3:0] robot_row,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic [9:0] VGA_R,
  output logic [9:0] VGA_G,
  output logic [9:0] VGA_B
);

  localparam int         DEPTH   = TILE_COLS * TILE_ROWS;
  localparam logic [9:0] DEPTH_W = 10'(DEPTH);

  logic rst_n;
  logic unused_keys;
  assign rst_n       = KEY[0];
  assign unused_keys = ^KEY[3:1];

  // Tile RAM is never reset so the map survives a KEY[0] press.
  logic [2:0] tile_ram [DEPTH];

  always_ff @(posedge CLOCK_50) begin
    if (map_we && ({1'b0, map_addr} < DEPTH_W)) begin
      tile_ram[map_addr] <= map_data;
    end
  end

  logic in_area;
  assign in_area = video_on && (pixel_x < 10'd640) && (pixel_y < 10'd480);

  logic [4:0] s1_col;
  logic [3:0] s1_row;
  logic [4:0] s1_ox;
  logic [4:0] s1_oy;
  logic       s1_video;
  logic       s1_hs;
  logic       s1_vs;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      s1_col   <= '0;
      s1_row   <= '0;
      s1_ox    <= '0;
      s1_oy    <= '0;
      s1_video <= 1'b0;
      s1_hs    <= 1'b1;
      s1_vs    <= 1'b1;
    end else if (p_tick) begin
      s1_col   <= pixel_x[9:5];
      s1_row   <= pixel_y[8:5];
      s1_ox    <= pixel_x[4:0];
      s1_oy    <= pixel_y[4:0];
      s1_video <= in_area;
      s1_hs    <= hs_in;
      s1_vs    <= vs_in;
    end
  end

  logic [9:0] s1_addr;
  logic       s1_addr_ok;
  assign s1_addr    = 10'(s1_row) * 10'(TILE_COLS) + 10'(s1_col);
  assign s1_addr_ok = s1_addr < DEPTH_W;

  logic [4:0] s2_col;
  logic [3:0] s2_row;
  logic [4:0] s2_ox;
  logic [4:0] s2_oy;
  logic       s2_video;
  logic       s2_hs;
  logic       s2_vs;
  logic [2:0] s2_tile;

  // A same-edge write to the address being read returns the previous contents.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      s2_col   <= '0;
      s2_row   <= '0;
      s2_ox    <= '0;
      s2_oy    <= '0;
      s2_video <= 1'b0;
      s2_hs    <= 1'b1;
      s2_vs    <= 1'b1;
      s2_tile  <= '0;
    end else if (p_tick) begin
      s2_col   <= s1_col;
      s2_row   <= s1_row;
      s2_ox    <= s1_ox;
      s2_oy    <= s1_oy;
      s2_video <= s1_video;
      s2_hs    <= s1_hs;
      s2_vs    <= s1_vs;
      s2_tile  <= s1_addr_ok ? tile_ram[s1_addr[8:0]] : 3'd0;
    end
  end

  // Robot position only changes at the start of vertical blanking.
  logic [4:0] robot_col_q;
  logic [3:0] robot_row_q;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      robot_col_q <= '0;
      robot_row_q <= '0;
    end else if (p_tick && (pixel_x == 10'd0) && (pixel_y == 10'd480)) begin
      robot_col_q <= robot_col;
      robot_row_q <= robot_row;
    end
  end

  logic robot_valid;
  logic robot_hit;
  logic h_body;
  logic v_body;
  assign robot_valid = ({1'b0, robot_col_q} < 6'(TILE_COLS)) &&
                       ({1'b0, robot_row_q} < 5'(TILE_ROWS));
  assign robot_hit   = robot_valid && (s2_col == robot_col_q) && (s2_row == robot_row_q) &&
                       (s2_ox >= 5'd10) && (s2_ox <= 5'd21) &&
                       (s2_oy >= 5'd10) && (s2_oy <= 5'd21);
  assign h_body      = (s2_oy >= 5'd8) && (s2_oy <= 5'd23);
  assign v_body      = (s2_ox >= 5'd8) && (s2_ox <= 5'd23);

  logic body;

  always_comb begin
    body = 1'b0;
    case (s2_tile)
      3'd1, 3'd4: body = h_body;
      3'd2:       body = v_body;
      3'd3:       body = h_body || v_body;
      default:    body = 1'b0;
    endcase
  end

  logic [9:0] next_r;
  logic [9:0] next_g;
  logic [9:0] next_b;

  always_comb begin
    next_r = '0;
    next_g = '0;
    next_b = '0;
    if (s2_video) begin
      if (robot_hit) begin
        next_r = 10'h3FF;
      end else if (body && (s2_tile == 3'd4)) begin
        next_r = 10'h200;
        next_g = 10'h100;
      end else if (body) begin
        next_r = 10'h2AA;
        next_g = 10'h2AA;
        next_b = 10'h2AA;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
    end else if (p_tick) begin
      VGA_R  <= next_r;
      VGA_G  <= next_g;
      VGA_B  <= next_b;
      VGA_HS <= s2_hs;
      VGA_VS <= s2_vs;
    end
  end

endmodule
